// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   - rx_state_e : receive FSM states
//   - PAR_*      : parity mode encodings for the PARITY parameter
//   - maj3       : 2-of-3 majority used by the sample voter
//   - params_ok  : legality check applied to the receiver parameters
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Majority of three samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // True when the receiver parameter set is supported.
  function automatic bit params_ok(input int width, input int os, input int parity,
                                   input int stop_bits, input int msb_first);
    return (width >= 1) && (width <= 16) &&
           (os >= 4) && ((os % 2) == 0) &&
           (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           ((msb_first == 0) || (msb_first == 1));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning and bit timing for the UART receiver.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   rx_si_i    raw serial input (asynchronous, idle high)
//   restart_i  restart the sample counter at 1 (frame start detected)
//   vote_o     majority of the last three synchronised samples
//   fall_o     synchronised 1->0 transition seen this cycle
//   mid_o      sample counter is at the mid-bit position
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_si_i,
  input  logic restart_i,
  output logic vote_o,
  output logic fall_o,
  output logic mid_o
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic          sync1_q, sync2_q;
  logic [2:0]    vote_sr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser and vote shift register; idle-high reset values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      vote_sr_q <= 3'b111;
    end else begin
      sync1_q   <= rx_si_i;
      sync2_q   <= sync1_q;
      vote_sr_q <= {vote_sr_q[1:0], sync2_q};
    end
  end

  // Sample counter next state: restart at 1 because the cycle that detected
  // the edge already counts as sample 0 of the start bit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CW'(OVERSAMPLE - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Sample counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // vote_sr_q[0] holds the previous synchronised sample, so comparing it
  // with sync2_q gives a clean edge detect on the synchronised line.
  assign vote_o = maj3(vote_sr_q);
  assign fall_o = vote_sr_q[0] & ~sync2_q;
  assign mid_o  = (cnt_q == CW'(OVERSAMPLE / 2));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver with one-entry holding register.
//   clk, rst       clock / asynchronous active-high reset
//   en             receiver enable (0 abandons any frame in progress)
//   rx_si          serial input, idle high
//   rx_data_ack    consumer acknowledge of the held frame
//   rx_po          held frame data
//   rx_ready       holding register has an unacknowledged frame
//   rx_busy        frame reception in progress
//   rx_frame_err   held frame had a low stop bit
//   rx_parity_err  held frame had a parity mismatch
//   rx_overrun     a frame was dropped while rx_ready was set
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx_si,
  input  logic             rx_data_ack,
  output logic [WIDTH-1:0] rx_po,
  output logic             rx_ready,
  output logic             rx_busy,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_overrun
);

  if (!params_ok(WIDTH, OVERSAMPLE, PARITY, STOP_BITS, MSB_FIRST)) begin : g_bad_params
    $error("uart_rx_param: unsupported parameter combination");
  end

  localparam int   BCW     = $clog2(WIDTH + 1);
  localparam logic ODD_SEL = (PARITY == PAR_ODD);

  logic vote_s, fall_s, mid_s, restart_s, done_s, done_ferr_s;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_si_i  (rx_si),
    .restart_i(restart_s),
    .vote_o   (vote_s),
    .fall_o   (fall_s),
    .mid_o    (mid_s)
  );

  rx_state_e        state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] po_q, po_d;
  logic             ready_q, ready_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;

  // Receive FSM next-state: one decision per mid-bit strobe.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    restart_s   = 1'b0;
    done_s      = 1'b0;
    done_ferr_s = ferr_q | ~vote_s;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall_s) begin
            state_d   = ST_START;
            restart_s = 1'b1;
            bit_cnt_d = '0;
            par_d     = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s) begin
            // A high mid-bit vote means the edge was a glitch.
            state_d = vote_s ? ST_IDLE : ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            if (MSB_FIRST != 0) begin
              shreg_d = (shreg_q << 1) | WIDTH'(vote_s);
            end else begin
              shreg_d = (shreg_q >> 1) | (WIDTH'(vote_s) << (WIDTH - 1));
            end
            par_d = par_q ^ vote_s;
            if (bit_cnt_q == BCW'(WIDTH - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (mid_s) begin
            perr_d    = ((par_q ^ vote_s) != ODD_SEL);
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (mid_s) begin
            if (!vote_s) begin
              ferr_d = 1'b1;
            end else begin
              ferr_d = ferr_q;
            end
            // Complete at mid-bit of the last stop bit so a following start
            // edge is not missed.
            if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
              done_s  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Receive FSM and frame assembly registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Holding register next-state: load, drop-with-overrun, or acknowledge.
  always_comb begin
    po_d         = po_q;
    ready_d      = ready_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (done_s) begin
      if (!ready_q || rx_data_ack) begin
        po_d         = shreg_q;
        ready_d      = 1'b1;
        frame_err_d  = done_ferr_s;
        parity_err_d = perr_q;
        // An ack in the same cycle still retires any earlier overrun.
        if (ready_q) begin
          overrun_d = 1'b0;
        end else begin
          overrun_d = overrun_q;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ready_q && rx_data_ack) begin
      ready_d      = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      ready_d = ready_q;
    end
  end

  // Holding register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_q         <= '0;
      ready_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      po_q         <= po_d;
      ready_q      <= ready_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_po         = po_q;
  assign rx_ready      = ready_q;
  assign rx_busy       = busy_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_parity_err = parity_err_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param. Four receivers differ in one parameter:
//   0: no parity, 1 stop, MSB first   1: even parity
//   2: two stop bits                  3: LSB first
// A single serial line is steered to the receiver selected by sel.
module tb_uart_rx_param;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       line = 1'b1;
  int         sel = 0;
  logic [3:0] ack = 4'b0000;
  logic [3:0] rxl;
  logic [7:0] po [4];
  logic [3:0] ready, busy, ferr, perr, ovr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Route the serial line to the selected receiver; others see idle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rxl[i] = (sel == i) ? line : 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_rx_param #(
      .WIDTH     (8),
      .OVERSAMPLE(OS),
      .PARITY    ((g == 1) ? 1 : 0),
      .STOP_BITS ((g == 2) ? 2 : 1),
      .MSB_FIRST ((g == 3) ? 0 : 1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .rx_si        (rxl[g]),
      .rx_data_ack  (ack[g]),
      .rx_po        (po[g]),
      .rx_ready     (ready[g]),
      .rx_busy      (busy[g]),
      .rx_frame_err (ferr[g]),
      .rx_parity_err(perr[g]),
      .rx_overrun   (ovr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int s);
    ack[s] = 1'b1;
    idle(1);
    ack[s] = 1'b0;
  endtask

  // par < 0: no parity bit. spike >= 0: invert one sample in that data bit.
  task automatic send(input int s, input logic [7:0] d, input bit msb, input int par,
                      input bit stop1, input int nstop, input bit stop2, input int spike);
    logic q[$];
    sel = s;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(msb ? d[7-i] : d[i]);
    if (par >= 0) q.push_back(par[0]);
    q.push_back(stop1);
    if (nstop == 2) q.push_back(stop2);
    for (int b = 0; b < q.size(); b++) begin
      for (int c = 0; c < OS; c++) begin
        line = (spike == b - 1 && c == 2) ? ~q[b] : q[b];
        idle(1);
      end
    end
    line = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    check("rst_po",    po[0],   32'h0);
    check("rst_ready", ready[0], 32'h0);
    check("rst_busy",  busy[0],  32'h0);
    check("rst_flags", {ferr[0], perr[0], ovr[0]}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Basic frame, then ack keeps data
    send(0, 8'hA5, 1'b1, -1, 1'b1, 1, 1'b1, -1);
    idle(2);
    check("a5_po",    po[0], 32'hA5);
    check("a5_ready", ready[0], 32'h1);
    check("a5_flags", {ferr[0], perr[0], ovr[0]}, 32'h0);
    check("a5_busy",  busy[0], 32'h0);
    do_ack(0);
    check("ack_ready", ready[0], 32'h0);
    check("ack_po",    po[0], 32'hA5);

    // Even parity, wrong then right parity bit
    send(1, 8'hC3, 1'b1, 1, 1'b1, 1, 1'b1, -1);
    idle(2);
    check("par_bad_po",   po[1], 32'hC3);
    check("par_bad_perr", perr[1], 32'h1);
    check("par_bad_ferr", ferr[1], 32'h0);
    do_ack(1);
    check("par_ack_perr", perr[1], 32'h0);
    send(1, 8'hC3, 1'b1, 0, 1'b1, 1, 1'b1, -1);
    idle(2);
    check("par_ok_perr",  perr[1], 32'h0);
    check("par_ok_ready", ready[1], 32'h1);

    // Two stop bits, second low
    send(2, 8'h3C, 1'b1, -1, 1'b1, 2, 1'b0, -1);
    idle(4);
    check("stop2_po",   po[2], 32'h3C);
    check("stop2_ferr", ferr[2], 32'h1);

    // LSB first
    send(3, 8'h01, 1'b0, -1, 1'b1, 1, 1'b1, -1);
    idle(2);
    check("lsb_po",   po[3], 32'h01);
    check("lsb_ferr", ferr[3], 32'h0);

    // Two-cycle glitch on idle line
    sel = 0;
    idle(4);
    line = 1'b0;
    idle(2);
    line = 1'b1;
    idle(2);
    check("glitch_busy_hi", busy[0], 32'h1);
    idle(6);
    check("glitch_busy_lo", busy[0], 32'h0);
    idle(20);
    check("glitch_ready", ready[0], 32'h0);

    // One-sample spike inside data bit 3
    send(0, 8'h96, 1'b1, -1, 1'b1, 1, 1'b1, 3);
    idle(2);
    check("spike_po",    po[0], 32'h96);
    check("spike_ready", ready[0], 32'h1);
    do_ack(0);
    idle(4);

    // Overrun, then a frame completing with ack in the same cycle
    send(0, 8'h11, 1'b1, -1, 1'b1, 1, 1'b1, -1);
    send(0, 8'h22, 1'b1, -1, 1'b1, 1, 1'b1, -1);
    check("ovr_po",    po[0], 32'h11);
    check("ovr_flag",  ovr[0], 32'h1);
    check("ovr_ready", ready[0], 32'h1);
    fork
      send(0, 8'h33, 1'b1, -1, 1'b1, 1, 1'b1, -1);
      begin
        repeat (78) @(posedge clk);
        #1;
        ack[0] = 1'b1;
        idle(1);
        ack[0] = 1'b0;
      end
    join
    check("ackdone_po",    po[0], 32'h33);
    check("ackdone_ready", ready[0], 32'h1);
    check("ackdone_ovr",   ovr[0], 32'h0);
    idle(4);

    // Reset in the middle of a data phase
    line = 1'b0;
    idle(20);
    check("mid_busy", busy[0], 32'h1);
    rst = 1'b1;
    #1;
    check("arst_po",    po[0], 32'h0);
    check("arst_ready", ready[0], 32'h0);
    check("arst_busy",  busy[0], 32'h0);
    line = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(4);
    send(0, 8'h5A, 1'b1, -1, 1'b1, 1, 1'b1, -1);
    idle(2);
    check("post_rst_po",    po[0], 32'h5A);
    check("post_rst_ready", ready[0], 32'h1);
    check("post_rst_flags", {ferr[0], perr[0], ovr[0]}, 32'h0);
    do_ack(0);
    idle(4);

    // Drop enable mid-frame; re-enable with the line low
    line = 1'b0;
    idle(24);
    check("en_busy_hi", busy[0], 32'h1);
    en = 1'b0;
    idle(2);
    check("en_busy_lo", busy[0], 32'h0);
    idle(20);
    en = 1'b1;
    idle(100);
    check("en_low_busy",  busy[0], 32'h0);
    check("en_low_ready", ready[0], 32'h0);
    line = 1'b1;
    idle(10);

    // Break: line held low for longer than a frame
    line = 1'b0;
    idle(100);
    check("brk_ready", ready[0], 32'h1);
    check("brk_po",    po[0], 32'h0);
    check("brk_ferr",  ferr[0], 32'h1);
    check("brk_busy",  busy[0], 32'h0);
    line = 1'b1;
    idle(20);
    check("brk_rel_busy", busy[0], 32'h0);
    do_ack(0);
    check("brk_ack_ferr", ferr[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
